// File: rtl/tod_counter.sv
// BCD time-of-day counter: prescaled tick input, read-latch snapshot and an
// optional alarm comparator built only when TOD_ALARM_EN is defined.
module tod_counter #(
   parameter int TICKS_60 = 6,
   parameter int TICKS_50 = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tod_tick,
   input  logic       sel_50hz,
   input  logic       wr_en,
   input  logic       wr_alarm,
   input  logic [1:0] addr,
   input  logic [7:0] wr_data,
   input  logic       rd_en,
   output logic [7:0] rd_data,
   output logic       alarm_irq
);

   localparam int TMAX = (TICKS_60 > TICKS_50) ? TICKS_60 : TICKS_50;
   localparam int PW   = (TMAX > 1) ? $clog2(TMAX) : 1;

   typedef enum logic [1:0] {
      REG_TENTHS = 2'd0,
      REG_SEC    = 2'd1,
      REG_MIN    = 2'd2,
      REG_HOURS  = 2'd3
   } reg_sel_e;

   logic [3:0]      tenths_q, tenths_d;
   logic [6:0]      sec_q, sec_d;
   logic [6:0]      min_q, min_d;
   logic [4:0]      hr_q, hr_d;
   logic            pm_q, pm_d;
   logic [PW-1:0]   presc_q, presc_d, div_m1;
   logic            run_q, run_d;
   logic            latch_q, latch_d;
   logic [3:0][7:0] snap_q, snap_d;
   logic [3:0][7:0] live;
   logic            time_wr;

   logic [3:0] ten_inc, su_inc, mu_inc;
   logic [2:0] st_inc, mt_inc;
   logic [6:0] sec_inc, min_inc;
   logic [4:0] hr_inc;
   logic       pm_inc;
   logic       c_t, c_su, c_st, c_mu, c_mt;

   // Returns {carry, next}; a digit above max steps modulo its width without carry.
   function automatic logic [4:0] inc_digit4(input logic [3:0] d, input logic [3:0] max);
      return (d == max) ? 5'b1_0000 : {1'b0, d + 4'd1};
   endfunction

   function automatic logic [3:0] inc_digit3(input logic [2:0] d, input logic [2:0] max);
      return (d == max) ? 4'b1_000 : {1'b0, d + 3'd1};
   endfunction

   // Full one-tenth increment with the carry rippling through every field in one cycle.
   always_comb begin
      {c_t,  ten_inc} = inc_digit4(tenths_q,   4'd9);
      {c_su, su_inc}  = inc_digit4(sec_q[3:0], 4'd9);
      {c_st, st_inc}  = inc_digit3(sec_q[6:4], 3'd5);
      {c_mu, mu_inc}  = inc_digit4(min_q[3:0], 4'd9);
      {c_mt, mt_inc}  = inc_digit3(min_q[6:4], 3'd5);
      sec_inc = sec_q;
      min_inc = min_q;
      hr_inc  = hr_q;
      pm_inc  = pm_q;
      if (c_t)
         sec_inc = c_su ? {st_inc, su_inc} : {sec_q[6:4], su_inc};
      if (c_t && c_su && c_st)
         min_inc = c_mu ? {mt_inc, mu_inc} : {min_q[6:4], mu_inc};
      if (c_t && c_su && c_st && c_mu && c_mt) begin
         if (hr_q == 5'h11) begin
            hr_inc = 5'h12;
            pm_inc = ~pm_q;
         end else if (hr_q == 5'h12) begin
            hr_inc = 5'h01;
         end else if (hr_q[3:0] == 4'd9) begin
            hr_inc = {~hr_q[4], 4'd0};
         end else begin
            hr_inc = {hr_q[4], hr_q[3:0] + 4'd1};
         end
      end
   end

   assign live[0] = {4'b0000, tenths_q};
   assign live[1] = {1'b0, sec_q};
   assign live[2] = {1'b0, min_q};
   assign live[3] = {pm_q, 2'b00, hr_q};

   assign rd_data = latch_q ? snap_q[addr] : live[addr];
   assign time_wr = wr_en & ~wr_alarm;
   assign div_m1  = sel_50hz ? PW'(TICKS_50 - 1) : PW'(TICKS_60 - 1);

   always_comb begin
      // NOTE: every _d gets its current value first so no path through this block infers a latch.
      tenths_d = tenths_q;
      sec_d    = sec_q;
      min_d    = min_q;
      hr_d     = hr_q;
      pm_d     = pm_q;
      presc_d  = presc_q;
      run_d    = run_q;
      latch_d  = latch_q;
      snap_d   = snap_q;

      if (time_wr) begin
         unique case (reg_sel_e'(addr))
            REG_TENTHS: begin
               tenths_d = wr_data[3:0];
               run_d    = 1'b1;
            end
            REG_SEC:    sec_d = wr_data[6:0];
            REG_MIN:    min_d = wr_data[6:0];
            REG_HOURS: begin
               hr_d    = wr_data[4:0];
               pm_d    = wr_data[7];
               run_d   = 1'b0;
               presc_d = '0;
            end
         endcase
      end else if (tod_tick && run_q) begin
         if (presc_q >= div_m1) begin
            presc_d  = '0;
            tenths_d = ten_inc;
            sec_d    = sec_inc;
            min_d    = min_inc;
            hr_d     = hr_inc;
            pm_d     = pm_inc;
         end else begin
            presc_d = presc_q + 1'b1;
         end
      end

      // Snapshot uses the pre-edge values, i.e. exactly what is being read this cycle.
      if (rd_en) begin
         if (reg_sel_e'(addr) == REG_HOURS && !latch_q) begin
            snap_d  = live;
            latch_d = 1'b1;
         end else if (reg_sel_e'(addr) == REG_TENTHS && latch_q) begin
            latch_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         tenths_q <= '0;
         sec_q    <= '0;
         min_q    <= '0;
         hr_q     <= 5'h01;
         pm_q     <= 1'b0;
         presc_q  <= '0;
         run_q    <= 1'b1;
         latch_q  <= 1'b0;
      end else begin
         tenths_q <= tenths_d;
         sec_q    <= sec_d;
         min_q    <= min_d;
         hr_q     <= hr_d;
         pm_q     <= pm_d;
         presc_q  <= presc_d;
         run_q    <= run_d;
         latch_q  <= latch_d;
      end
   end

   // NOTE: the snapshot bank is left unreset; it is only visible while latch_q is set, after a capture.
   always_ff @(posedge clk) begin
      snap_q <= snap_d;
   end

`ifdef TOD_ALARM_EN
   logic [3:0][7:0] alarm_q, alarm_d;
   logic            eq, eq_q, irq_q, irq_d;

   function automatic logic [7:0] reg_mask(input logic [1:0] a);
      case (a)
         2'd0:    return 8'h0F;
         2'd3:    return 8'h9F;
         default: return 8'h7F;
      endcase
   endfunction

   always_comb begin
      alarm_d = alarm_q;
      if (wr_en && wr_alarm)
         alarm_d[addr] = wr_data & reg_mask(addr);
      eq    = (alarm_q == live);
      irq_d = eq & ~eq_q;
   end

   // eq_q resets high so a match present right after reset is not reported as a new one.
   always_ff @(posedge clk) begin
      if (rst) begin
         alarm_q <= '0;
         eq_q    <= 1'b1;
         irq_q   <= 1'b0;
      end else begin
         alarm_q <= alarm_d;
         eq_q    <= eq;
         irq_q   <= irq_d;
      end
   end

   assign alarm_irq = irq_q;
`else
   assign alarm_irq = 1'b0;
`endif

endmodule

// File: tb/tb_tod_counter.sv
// Self-checking bench for tod_counter: directed scenarios plus randomized traffic
// compared against a digit-level behavioural model of the clock.
`timescale 1ns/1ps
module tb_tod_counter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tod_tick = 1'b0;
   logic       sel_50hz = 1'b0;
   logic       wr_en = 1'b0;
   logic       wr_alarm = 1'b0;
   logic [1:0] addr = 2'd0;
   logic [7:0] wr_data = 8'h00;
   logic       rd_en = 1'b0;
   logic [7:0] rd_data;
   logic       alarm_irq;

   int n_tests = 0;
   int n_fail  = 0;

`ifdef TOD_ALARM_EN
   localparam bit ALARM_EN = 1'b1;
`else
   localparam bit ALARM_EN = 1'b0;
`endif

   always #5 clk = ~clk;

   tod_counter #(.TICKS_60(6), .TICKS_50(5)) dut (
      .clk       (clk),
      .rst       (rst),
      .tod_tick  (tod_tick),
      .sel_50hz  (sel_50hz),
      .wr_en     (wr_en),
      .wr_alarm  (wr_alarm),
      .addr      (addr),
      .wr_data   (wr_data),
      .rd_en     (rd_en),
      .rd_data   (rd_data),
      .alarm_irq (alarm_irq)
   );

   // Reference model: one int per BCD digit plus the control flags.
   int         m_ten, m_su, m_st, m_mu, m_mt, m_hu, m_ht, m_pm, m_presc;
   bit         m_run, m_latch, m_eq_prev, m_irq;
   logic [7:0] m_snap [4];
   logic [7:0] m_alarm [4];
   int         cyc_no = 0, irq_count = 0, irq_at = -1, irq_diff = 0;

   function automatic logic [7:0] live_reg(input int a);
      case (a)
         0:       return 8'(m_ten);
         1:       return 8'(m_st * 16 + m_su);
         2:       return 8'(m_mt * 16 + m_mu);
         default: return 8'(m_pm * 128 + m_ht * 16 + m_hu);
      endcase
   endfunction

   function automatic logic [31:0] model_all();
      logic [31:0] v;
      for (int i = 0; i < 4; i++) v[i*8 +: 8] = m_latch ? m_snap[i] : live_reg(i);
      return v;
   endfunction

   function automatic int bump(input int d, input int max, input int modv, output bit carry);
      carry = (d == max);
      return carry ? 0 : (d + 1) % modv;
   endfunction

   task automatic model_reset();
      m_ten = 0; m_su = 0; m_st = 0; m_mu = 0; m_mt = 0; m_hu = 1; m_ht = 0; m_pm = 0;
      m_presc = 0; m_run = 1; m_latch = 0; m_eq_prev = 1; m_irq = 0;
      for (int i = 0; i < 4; i++) begin m_alarm[i] = 8'h00; m_snap[i] = 8'h00; end
   endtask

   task automatic model_advance();
      bit c;
      m_ten = bump(m_ten, 9, 16, c); if (!c) return;
      m_su  = bump(m_su,  9, 16, c); if (!c) return;
      m_st  = bump(m_st,  5,  8, c); if (!c) return;
      m_mu  = bump(m_mu,  9, 16, c); if (!c) return;
      m_mt  = bump(m_mt,  5,  8, c); if (!c) return;
      if (m_ht == 1 && m_hu == 1) begin m_hu = 2; m_pm = 1 - m_pm; end
      else if (m_ht == 1 && m_hu == 2) begin m_ht = 0; m_hu = 1; end
      else if (m_hu == 9) begin m_hu = 0; m_ht = (m_ht + 1) % 2; end
      else m_hu = (m_hu + 1) % 16;
   endtask

   // Applies the currently driven inputs to the model as one clock edge.
   task automatic model_step();
      bit eq_now;
      int d, div;
      d = int'(wr_data);
      eq_now = 1'b1;
      for (int i = 0; i < 4; i++) if (live_reg(i) !== m_alarm[i]) eq_now = 1'b0;
      m_irq     = ALARM_EN && eq_now && !m_eq_prev;
      m_eq_prev = eq_now;
      if (rd_en) begin
         if (addr == 2'd3 && !m_latch) begin
            for (int i = 0; i < 4; i++) m_snap[i] = live_reg(i);
            m_latch = 1'b1;
         end else if (addr == 2'd0 && m_latch) begin
            m_latch = 1'b0;
         end
      end
      if (ALARM_EN && wr_en && wr_alarm)
         m_alarm[addr] = 8'(d) & ((addr == 2'd0) ? 8'h0F : (addr == 2'd3) ? 8'h9F : 8'h7F);
      if (wr_en && !wr_alarm) begin
         case (addr)
            2'd0: begin m_ten = d % 16; m_run = 1'b1; end
            2'd1: begin m_su = d % 16; m_st = (d / 16) % 8; end
            2'd2: begin m_mu = d % 16; m_mt = (d / 16) % 8; end
            default: begin
               m_hu = d % 16; m_ht = (d / 16) % 2; m_pm = d / 128;
               m_run = 1'b0; m_presc = 0;
            end
         endcase
      end else if (tod_tick && m_run) begin
         div = sel_50hz ? 5 : 6;
         if (m_presc >= div - 1) begin m_presc = 0; model_advance(); end
         else m_presc++;
      end
   endtask

   task automatic cyc(input bit t, input bit w, input bit wa, input logic [1:0] a,
                      input logic [7:0] d, input bit r);
      tod_tick = t; wr_en = w; wr_alarm = wa; addr = a; wr_data = d; rd_en = r;
      model_step();
      @(posedge clk); #1;
      cyc_no++;
      if (alarm_irq === 1'b1) begin irq_count++; irq_at = cyc_no; end
      if (alarm_irq !== m_irq) irq_diff++;
      tod_tick = 1'b0; wr_en = 1'b0; wr_alarm = 1'b0; rd_en = 1'b0;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0);
   endtask

   task automatic wr(input logic [1:0] a, input logic [7:0] d);
      cyc(1'b0, 1'b1, 1'b0, a, d, 1'b0);
   endtask

   task automatic wra(input logic [1:0] a, input logic [7:0] d);
      cyc(1'b0, 1'b1, 1'b1, a, d, 1'b0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0);
   endtask

   task automatic peek(input logic [1:0] a, output logic [7:0] v);
      addr = a; #0.1; v = rd_data;
   endtask

   task automatic read_all(output logic [31:0] v);
      logic [7:0] b;
      for (int i = 0; i < 4; i++) begin peek(2'(i), b); v[i*8 +: 8] = b; end
   endtask

   // Reset is held with a tick, an hours write and a latching read all active.
   task automatic do_reset();
      rst = 1'b1; tod_tick = 1'b1; wr_en = 1'b1; wr_alarm = 1'b0;
      addr = 2'd3; wr_data = 8'h55; rd_en = 1'b1; sel_50hz = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0; tod_tick = 1'b0; wr_en = 1'b0; rd_en = 1'b0; addr = 2'd0; wr_data = 8'h00;
      model_reset();
      irq_count = 0; irq_at = -1; irq_diff = 0;
   endtask

   task automatic test_reset();
      logic [31:0] v;
      do_reset();
      read_all(v);
      n_tests++;
      if (v !== 32'h01000000) begin n_fail++; $display("FAIL reset_time: got %h expected %h", v, 32'h01000000); end
      idle(1);
      n_tests++;
      if (alarm_irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b expected 0", alarm_irq); end
      cyc(1'b0, 1'b0, 1'b0, 2'd3, 8'h00, 1'b1);
      ticks(6);
      do_reset();
      ticks(6);
      read_all(v);
      n_tests++;
      if (v !== 32'h01000001) begin n_fail++; $display("FAIL reset_unlatch: got %h expected %h", v, 32'h01000001); end
   endtask

   task automatic test_prescale();
      logic [31:0] v;
      do_reset();
      ticks(5);
      read_all(v);
      n_tests++;
      if (v !== 32'h01000000) begin n_fail++; $display("FAIL presc60_5: got %h expected %h", v, 32'h01000000); end
      ticks(1);
      read_all(v);
      n_tests++;
      if (v !== 32'h01000001) begin n_fail++; $display("FAIL presc60_6: got %h expected %h", v, 32'h01000001); end
      sel_50hz = 1'b1;
      ticks(4);
      read_all(v);
      n_tests++;
      if (v !== 32'h01000001) begin n_fail++; $display("FAIL presc50_4: got %h expected %h", v, 32'h01000001); end
      ticks(1);
      read_all(v);
      n_tests++;
      if (v !== 32'h01000002) begin n_fail++; $display("FAIL presc50_5: got %h expected %h", v, 32'h01000002); end
      sel_50hz = 1'b0;
   endtask

   task automatic test_rollover();
      logic [31:0] v;
      do_reset();
      wr(2'd3, 8'h11); wr(2'd2, 8'h59); wr(2'd1, 8'h59); wr(2'd0, 8'h09);
      ticks(6);
      read_all(v);
      n_tests++;
      if (v !== 32'h92000000) begin n_fail++; $display("FAIL roll_11_12: got %h expected %h", v, 32'h92000000); end
      wr(2'd3, 8'h92); wr(2'd2, 8'h59); wr(2'd1, 8'h59); wr(2'd0, 8'h09);
      ticks(6);
      read_all(v);
      n_tests++;
      if (v !== 32'h81000000) begin n_fail++; $display("FAIL roll_12_01: got %h expected %h", v, 32'h81000000); end
   endtask

   task automatic test_stop();
      logic [31:0] v;
      do_reset();
      ticks(3);
      wr(2'd3, 8'h05);
      ticks(20);
      read_all(v);
      n_tests++;
      if (v !== 32'h05000000) begin n_fail++; $display("FAIL stop_hold: got %h expected %h", v, 32'h05000000); end
      wr(2'd0, 8'h00);
      ticks(5);
      read_all(v);
      n_tests++;
      if (v !== 32'h05000000) begin n_fail++; $display("FAIL stop_presc_clr: got %h expected %h", v, 32'h05000000); end
      ticks(1);
      read_all(v);
      n_tests++;
      if (v !== 32'h05000001) begin n_fail++; $display("FAIL stop_resume: got %h expected %h", v, 32'h05000001); end
   endtask

   task automatic test_latch();
      logic [31:0] v;
      logic [7:0]  b;
      do_reset();
      ticks(54);
      read_all(v);
      n_tests++;
      if (v !== 32'h01000009) begin n_fail++; $display("FAIL latch_pre: got %h expected %h", v, 32'h01000009); end
      rd_en = 1'b1; peek(2'd3, b);
      n_tests++;
      if (b !== 8'h01) begin n_fail++; $display("FAIL latch_capture_rd: got %h expected 01", b); end
      cyc(1'b0, 1'b0, 1'b0, 2'd3, 8'h00, 1'b1);
      ticks(6);
      peek(2'd1, b);
      n_tests++;
      if (b !== 8'h00) begin n_fail++; $display("FAIL latch_sec_snap: got %h expected 00", b); end
      peek(2'd0, b);
      n_tests++;
      if (b !== 8'h09) begin n_fail++; $display("FAIL latch_ten_snap: got %h expected 09", b); end
      cyc(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b1);
      peek(2'd1, b);
      n_tests++;
      if (b !== 8'h01) begin n_fail++; $display("FAIL latch_released: got %h expected 01", b); end
   endtask

   task automatic test_write_tick();
      logic [31:0] v;
      do_reset();
      ticks(5);
      cyc(1'b1, 1'b1, 1'b0, 2'd1, 8'hA5, 1'b0);
      read_all(v);
      n_tests++;
      if (v !== 32'h01002500) begin n_fail++; $display("FAIL wrtick_drop: got %h expected %h", v, 32'h01002500); end
      ticks(1);
      read_all(v);
      n_tests++;
      if (v !== 32'h01002501) begin n_fail++; $display("FAIL wrtick_presc: got %h expected %h", v, 32'h01002501); end
   endtask

   task automatic test_alarm();
      logic [31:0] v;
      int base;
      do_reset();
      wra(2'd1, 8'h01);
      wra(2'd3, 8'h01);
      read_all(v);
      n_tests++;
      if (v !== 32'h01000000) begin n_fail++; $display("FAIL alarm_time_untouched: got %h expected %h", v, 32'h01000000); end
      base = cyc_no;
      ticks(60);
      idle(5);
`ifdef TOD_ALARM_EN
      n_tests++;
      if (irq_count !== 1) begin n_fail++; $display("FAIL alarm_tick_count: got %0d expected 1", irq_count); end
      n_tests++;
      if (irq_at !== base + 61) begin n_fail++; $display("FAIL alarm_tick_cycle: got %0d expected %0d", irq_at, base + 61); end
      wr(2'd1, 8'h02);
      wr(2'd1, 8'h01);
      idle(3);
      n_tests++;
      if (irq_count !== 2) begin n_fail++; $display("FAIL alarm_write_count: got %0d expected 2", irq_count); end
`else
      n_tests++;
      if (irq_count !== 0) begin n_fail++; $display("FAIL alarm_disabled: got %0d pulses expected 0 (base %0d)", irq_count, base); end
`endif
   endtask

   task automatic test_random();
      logic [31:0] v, e;
      logic [7:0]  d;
      logic [7:0]  picks [6];
      picks[0] = 8'h09; picks[1] = 8'h59; picks[2] = 8'h11;
      picks[3] = 8'h12; picks[4] = 8'h92; picks[5] = 8'h19;
      do_reset();
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(15) == 0) sel_50hz = ~sel_50hz;
         d = ($urandom_range(1) == 0) ? 8'($urandom) : picks[$urandom_range(5)];
         cyc(1'($urandom_range(1)), ($urandom_range(7) == 0), 1'($urandom_range(1)),
             2'($urandom_range(3)), d, ($urandom_range(3) == 0));
         read_all(v);
         e = model_all();
         n_tests++;
         if (v !== e) begin n_fail++; $display("FAIL random_regs cycle %0d: got %h expected %h", i, v, e); end
      end
      n_tests++;
      if (irq_diff !== 0) begin n_fail++; $display("FAIL random_irq: got %0d irq differences expected 0", irq_diff); end
      sel_50hz = 1'b0;
   endtask

   initial begin
      test_reset();
      test_prescale();
      test_rollover();
      test_stop();
      test_latch();
      test_write_tick();
      test_alarm();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
